// File: rtl/agnus_pkg.sv
// rtl/agnus_pkg.sv - shared register addresses, state type and fetch-mode decode for the bitplane DMA
package agnus_pkg;

    localparam logic [7:0] BPLCON0_ADDR = 8'h80;
    localparam logic [7:0] DDFSTRT_ADDR = 8'h49;
    localparam logic [7:0] DDFSTOP_ADDR = 8'h4A;
    localparam logic [7:0] BPL1MOD_ADDR = 8'h84;
    localparam logic [7:0] BPL2MOD_ADDR = 8'h85;
    localparam logic [7:0] BPLPT_ADDR   = 8'h70;
    localparam logic [7:0] BPL1DAT_ADDR = 8'h88;
    localparam logic [7:0] FMODE_ADDR   = 8'hFE;
    localparam logic [7:0] IDLE_ADDR    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST
    } bpl_state_t;

    function automatic logic [1:0] fmode_to_f(input logic [1:0] fmode);
        case (fmode)
            2'd0:    return 2'd0;
            2'd3:    return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/agnus_bpl_slot_map.sv
// rtl/agnus_bpl_slot_map.sv - maps a fetch-slot position to the bitplane it serves in each resolution
module agnus_bpl_slot_map
    import agnus_pkg::*;
(
    input  logic [2:0] p,
    input  logic       hires,
    input  logic       shres,
    input  logic       aga,
    input  logic [3:0] planes,
    output logic       slot_valid,
    output logic [2:0] plane
);

    logic [3:0] num;

    // num is the 1-based plane number; 0 marks a slot no plane can use
    always_comb begin
        num = 4'd0;
        if (shres) begin
            num = p[0] ? 4'd1 : 4'd2;
        end else if (hires) begin
            case (p[1:0])
                2'd0:    num = 4'd4;
                2'd1:    num = 4'd2;
                2'd2:    num = 4'd3;
                default: num = 4'd1;
            endcase
        end else begin
            case (p)
                3'd0:    num = aga ? 4'd8 : 4'd0;
                3'd1:    num = 4'd4;
                3'd2:    num = 4'd6;
                3'd3:    num = 4'd2;
                3'd4:    num = aga ? 4'd7 : 4'd0;
                3'd5:    num = 4'd3;
                3'd6:    num = 4'd5;
                default: num = 4'd1;
            endcase
        end
        slot_valid = (num != 4'd0) && (num <= planes);
        plane      = 3'(num - 4'd1);
    end

endmodule

// File: rtl/agnus_bitplane_fetch.sv
// rtl/agnus_bitplane_fetch.sv - bitplane DMA slot sequencer with pointer, modulo and BPLxDAT issue
module agnus_bitplane_fetch
    import agnus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        aga,
    input  logic [7:0]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic [8:0]  hpos,
    input  logic        dma_en,
    output logic        dma,
    output logic [19:0] address_out,
    output logic [7:0]  reg_address_out
);

    logic        hires, shres;
    logic [3:0]  bpu;
    logic [7:0]  ddfstrt, ddfstop;
    logic [14:0] mod_odd, mod_even;
    logic [1:0]  fmode;
    logic [19:0] ptr     [8];
    logic [19:0] ptr_nxt [8];
    bpl_state_t  state;
    logic [4:0]  c;
    logic [2:0]  dma_plane;

    logic        step, in_slots, unit_end, issue, line_end, slot_valid;
    logic [1:0]  f;
    logic [4:0]  u_last;
    logic [3:0]  planes;
    logic [2:0]  slot_plane;
    logic [19:0] inc, mod_odd_w, mod_even_w;

    assign step     = clk7_en & ~hpos[0];
    assign f        = aga ? fmode_to_f(fmode) : 2'd0;
    assign u_last   = {f[1], |f, 3'b111};
    assign in_slots = (c[4:3] == u_last[4:3]);
    assign unit_end = (c == u_last);
    assign planes   = aga ? ((bpu > 4'd8) ? 4'd8 : bpu)
                          : ((bpu[2:0] > 3'd6) ? 4'd6 : {1'b0, bpu[2:0]});
    assign issue    = step & dma_en & (state != ST_IDLE) & in_slots & slot_valid;
    assign line_end = step & dma_en & (state == ST_LAST) & unit_end;
    assign inc      = 20'd1 << f;
    // Modulos are byte offsets: bit 0 drops and the sign extends over the word pointer
    assign mod_odd_w  = {{5{mod_odd[14]}}, mod_odd};
    assign mod_even_w = {{5{mod_even[14]}}, mod_even};

    agnus_bpl_slot_map u_slot_map (
        .p          (c[2:0]),
        .hires      (hires),
        .shres      (shres),
        .aga        (aga),
        .planes     (planes),
        .slot_valid (slot_valid),
        .plane      (slot_plane)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hires    <= 1'b0;
            shres    <= 1'b0;
            bpu      <= 4'd0;
            ddfstrt  <= 8'd0;
            ddfstop  <= 8'd0;
            mod_odd  <= 15'd0;
            mod_even <= 15'd0;
            fmode    <= 2'd0;
        end else if (clk7_en) begin
            case (reg_address_in)
                BPLCON0_ADDR: begin
                    hires <= data_in[15];
                    shres <= data_in[6];
                    bpu   <= {data_in[4], data_in[14:12]};
                end
                DDFSTRT_ADDR: ddfstrt  <= data_in[7:0];
                DDFSTOP_ADDR: ddfstop  <= data_in[7:0];
                BPL1MOD_ADDR: mod_odd  <= data_in[15:1];
                BPL2MOD_ADDR: mod_even <= data_in[15:1];
                FMODE_ADDR:   if (aga) fmode <= data_in[1:0];
                default: ;
            endcase
        end
    end

    // DMA arithmetic first, then a CPU write replaces only the half it targets
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            ptr_nxt[n] = ptr[n];
            if (issue && slot_plane == 3'(n))
                ptr_nxt[n] = ptr_nxt[n] + inc;
            if (line_end)
                ptr_nxt[n] = ptr_nxt[n] + (n[0] ? mod_even_w : mod_odd_w);
            if (reg_address_in == BPLPT_ADDR + 8'(2 * n))
                ptr_nxt[n][19:15] = {aga & data_in[4], data_in[3:0]};
            if (reg_address_in == BPLPT_ADDR + 8'(2 * n + 1))
                ptr_nxt[n][14:0] = data_in[15:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) ptr[n] <= 20'd0;
        end else if (clk7_en) begin
            for (int n = 0; n < 8; n++) ptr[n] <= ptr_nxt[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            c               <= 5'd0;
            dma             <= 1'b0;
            address_out     <= 20'd0;
            dma_plane       <= 3'd0;
            reg_address_out <= IDLE_ADDR;
        end else if (step) begin
            dma             <= issue;
            reg_address_out <= dma ? (BPL1DAT_ADDR + {5'd0, dma_plane}) : IDLE_ADDR;
            if (issue) begin
                address_out <= ptr[slot_plane];
                dma_plane   <= slot_plane;
            end
            if (!dma_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (hpos[8:1] == ddfstrt) begin
                            c     <= 5'd0;
                            state <= (hpos[8:1] == ddfstop) ? ST_LAST : ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        c <= unit_end ? 5'd0 : c + 5'd1;
                        if (hpos[8:1] == ddfstop) state <= ST_LAST;
                    end
                    ST_LAST: begin
                        c <= unit_end ? 5'd0 : c + 5'd1;
                        if (unit_end) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
